// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises bytes as start/data(LSB first)/stop frames, paced by an external baud strobe.
// Build option: define UART_TX_PARITY_EN to append an even parity bit after the data bits.
module uart_transmitter #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clock_edge,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  data_valid,
    output logic                  ready,
    output logic                  tx
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    logic parity_r;
    logic parity_s;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd5
    } state_t;
`endif

    state_t                 state_r;
    state_t                 state_s;
    logic [DATA_WIDTH-1:0]  shift_r;
    logic [DATA_WIDTH-1:0]  shift_s;
    logic [BIT_CNT_W-1:0]   bit_cnt_r;
    logic [BIT_CNT_W-1:0]   bit_cnt_s;
    logic                   stop_cnt_r;
    logic                   stop_cnt_s;
    logic                   tx_r;
    logic                   tx_s;

    // Next-state and next-output decode; every move except the accept waits for a baud strobe.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        bit_cnt_s  = bit_cnt_r;
        stop_cnt_s = stop_cnt_r;
        tx_s       = tx_r;
`ifdef UART_TX_PARITY_EN
        parity_s   = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                tx_s = 1'b1;
                if (data_valid) begin
                    state_s = ST_SYNC;
                    shift_s = data;
`ifdef UART_TX_PARITY_EN
                    parity_s = even_parity(data);
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            // Waiting for a fresh strobe so the start bit spans a full baud period.
            ST_SYNC: begin
                if (clock_edge) begin
                    state_s = ST_START;
                    tx_s    = 1'b0;
                end else begin
                    tx_s = 1'b1;
                end
            end
            ST_START: begin
                if (clock_edge) begin
                    state_s   = ST_DATA;
                    tx_s      = shift_r[0];
                    bit_cnt_s = {BIT_CNT_W{1'b0}};
                end else begin
                    tx_s = tx_r;
                end
            end
            ST_DATA: begin
                if (clock_edge) begin
                    shift_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
                    if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_s = ST_PARITY;
                        tx_s    = parity_r;
`else
                        state_s    = ST_STOP;
                        tx_s       = 1'b1;
                        stop_cnt_s = 1'b0;
`endif
                    end else begin
                        bit_cnt_s = bit_cnt_r + BIT_CNT_W'(1);
                        tx_s      = shift_r[1];
                    end
                end else begin
                    tx_s = tx_r;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (clock_edge) begin
                    state_s    = ST_STOP;
                    tx_s       = 1'b1;
                    stop_cnt_s = 1'b0;
                end else begin
                    tx_s = tx_r;
                end
            end
`endif
            ST_STOP: begin
                tx_s = 1'b1;
                if (clock_edge) begin
                    if (stop_cnt_r == STOP_LAST) begin
                        state_s    = ST_IDLE;
                        stop_cnt_s = 1'b0;
                    end else begin
                        stop_cnt_s = 1'b1;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                tx_s       = 1'b1;
                bit_cnt_s  = {BIT_CNT_W{1'b0}};
                stop_cnt_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame and forces the line high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            shift_r    <= {DATA_WIDTH{1'b0}};
            bit_cnt_r  <= {BIT_CNT_W{1'b0}};
            stop_cnt_r <= 1'b0;
            tx_r       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            bit_cnt_r  <= bit_cnt_s;
            stop_cnt_r <= stop_cnt_s;
            tx_r       <= tx_s;
`ifdef UART_TX_PARITY_EN
            parity_r   <= parity_s;
`endif
        end
    end

    assign ready = (state_r == ST_IDLE);
    assign tx    = tx_r;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed self-checking bench for uart_transmitter: one instance with 1 stop bit, one with 2 stop bits,
// both fed from the same stimulus; each test checks only the instance it targets.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic       clock_edge;
    logic [7:0] data;
    logic       data_valid;
    logic       tx_a;
    logic       ready_a;
    logic       tx_b;
    logic       ready_b;
    int         checks = 0;
    int         errors = 0;
    logic       smp;
    logic       stable;

    always #5 clk = ~clk;

    uart_transmitter #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .clock_edge(clock_edge), .data(data),
        .data_valid(data_valid), .ready(ready_a), .tx(tx_a)
    );

    uart_transmitter #(.DATA_WIDTH(8), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .clock_edge(clock_edge), .data(data),
        .data_valid(data_valid), .ready(ready_b), .tx(tx_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e);
        clock_edge = e;
        @(posedge clk);
        #1;
        clock_edge = 1'b0;
    endtask

    // One baud interval of n clk ending in a strobe; returns tx seen at the strobe and whether it held steady.
    task automatic baud(input int n, input int sel, output logic s, output logic st);
        logic v0;
        v0 = (sel != 0) ? tx_b : tx_a;
        st = 1'b1;
        for (int i = 0; i < n - 1; i++) begin
            step(1'b0);
            if (((sel != 0) ? tx_b : tx_a) !== v0) st = 1'b0;
        end
        s = (sel != 0) ? tx_b : tx_a;
        step(1'b1);
    endtask

    function automatic int spacing(input int irr, input int k);
        int pat[4] = '{3, 7, 2, 5};
        return (irr != 0) ? pat[k % 4] : 4;
    endfunction

    // Runs a frame that has just been (or is about to be) accepted, checking every bit at its strobe.
    task automatic check_frame(input string tag, input logic [7:0] b, input int sel, input int irr);
        logic [11:0] bits;
        int          nb;
        int          nst;
        logic        s;
        logic        st;
        nst = (sel != 0) ? 2 : 1;
`ifdef UART_TX_PARITY_EN
        bits = {2'b11, ^b, b, 1'b0};
        nb   = 10 + nst;
`else
        bits = {3'b111, b, 1'b0};
        nb   = 9 + nst;
`endif
        baud(spacing(irr, 0), sel, s, st);
        chk($sformatf("%s_sync_lvl", tag), {7'd0, s}, 8'd1);
        chk($sformatf("%s_sync_stable", tag), {7'd0, st}, 8'd1);
        for (int k = 0; k < nb; k++) begin
            chk($sformatf("%s_busy%0d", tag, k), {7'd0, (sel != 0) ? ready_b : ready_a}, 8'd0);
            baud(spacing(irr, k + 1), sel, s, st);
            chk($sformatf("%s_bit%0d", tag, k), {7'd0, s}, {7'd0, bits[k]});
            chk($sformatf("%s_hold%0d", tag, k), {7'd0, st}, 8'd1);
        end
        chk($sformatf("%s_ready_after", tag), {7'd0, (sel != 0) ? ready_b : ready_a}, 8'd1);
    endtask

    initial begin
        reset      = 1'b1;
        clock_edge = 1'b0;
        data       = 8'hFF;
        data_valid = 1'b1;

        // 1: reset dominates valid/strobe, then idle line stays high and ready
        for (int i = 0; i < 3; i++) begin
            step((i % 2) == 0);
            chk("t1_rst_tx", {7'd0, tx_a}, 8'd1);
            chk("t1_rst_ready", {7'd0, ready_a}, 8'd1);
        end
        reset      = 1'b0;
        data_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step((i % 4) == 3);
            chk("t1_idle_tx", {7'd0, tx_a}, 8'd1);
            chk("t1_idle_ready", {7'd0, ready_a}, 8'd1);
        end

        // 2: 0xA5 frame
        data       = 8'hA5;
        data_valid = 1'b1;
        step(1'b0);
        data_valid = 1'b0;
        chk("t2_ready_drop", {7'd0, ready_a}, 8'd0);
        chk("t2_tx_after_accept", {7'd0, tx_a}, 8'd1);
        check_frame("t2", 8'hA5, 0, 0);

        // 3: accept coincident with a strobe; that strobe must not start the frame
        data       = 8'h55;
        data_valid = 1'b1;
        step(1'b1);
        data_valid = 1'b0;
        chk("t3_tx_accept", {7'd0, tx_a}, 8'd1);
        chk("t3_ready_accept", {7'd0, ready_a}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            chk("t3_sync_hi", {7'd0, tx_a}, 8'd1);
        end
        step(1'b1);
        chk("t3_start_lo", {7'd0, tx_a}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            chk("t3_start_hold", {7'd0, tx_a}, 8'd0);
        end
        step(1'b1);
        chk("t3_bit0", {7'd0, tx_a}, 8'd1);
`ifdef UART_TX_PARITY_EN
        for (int i = 0; i < 10; i++) baud(4, 0, smp, stable);
`else
        for (int i = 0; i < 9; i++) baud(4, 0, smp, stable);
`endif
        chk("t3_ready_after", {7'd0, ready_a}, 8'd1);

        // 4: data_valid held across two frames; data changes while busy are ignored
        data       = 8'h00;
        data_valid = 1'b1;
        step(1'b0);
        data = 8'hFF;
        check_frame("t4a", 8'h00, 0, 0);
        check_frame("t4b", 8'hFF, 0, 0);
        data_valid = 1'b0;

        // 5: reset in the middle of 0x0F, then a clean 0x3C frame
        data       = 8'h0F;
        data_valid = 1'b1;
        step(1'b0);
        data_valid = 1'b0;
        for (int i = 0; i < 5; i++) baud(4, 0, smp, stable);
        chk("t5_bit3", {7'd0, tx_a}, 8'd1);
        chk("t5_busy", {7'd0, ready_a}, 8'd0);
        step(1'b0);
        reset = 1'b1;
        step(1'b1);
        reset = 1'b0;
        chk("t5_rst_tx", {7'd0, tx_a}, 8'd1);
        chk("t5_rst_ready", {7'd0, ready_a}, 8'd1);
        data       = 8'h3C;
        data_valid = 1'b1;
        step(1'b0);
        data_valid = 1'b0;
        check_frame("t5", 8'h3C, 0, 0);

        // 6: two stop bits with irregular strobe spacing
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        chk("t6_rst_ready", {7'd0, ready_b}, 8'd1);
        data       = 8'h07;
        data_valid = 1'b1;
        step(1'b0);
        data_valid = 1'b0;
        chk("t6_ready_drop", {7'd0, ready_b}, 8'd0);
        check_frame("t6", 8'h07, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
